// File: rtl/bsg_cache_to_dram_ctrl_pkg.sv
// Shared helpers for the cache-to-DRAM-controller bridge: tag and credit widths.
package bsg_cache_to_dram_ctrl_pkg;

    function automatic int lg_num_cache(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int credit_width(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bsg_cache_to_dram_ctrl_fifo.sv
// Small 1r1w FIFO, registered write, head visible the cycle after the write edge.
module bsg_cache_to_dram_ctrl_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wr_ptr, rd_ptr;
    logic [cnt_w-1:0]   cnt;
    logic               enq, deq;

    assign ready_o = (cnt != full_cnt);
    assign v_o     = (cnt != '0);
    assign data_o  = mem[rd_ptr];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            if (deq) rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
            unique case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/bsg_cache_to_dram_ctrl_rx_credits.sv
// Buffer-space credits: reserve a block per admitted tag, release one per delivered word.
module bsg_cache_to_dram_ctrl_rx_credits
    import bsg_cache_to_dram_ctrl_pkg::*;
#(
    parameter int max_p = 8,
    parameter int n_p   = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic reserve_i,
    input  logic release_i,
    output logic ok_o
);
    localparam int cw = credit_width(max_p);
    localparam logic [cw:0]   max_w = (cw+1)'(max_p);
    localparam logic [cw:0]   n_w   = (cw+1)'(n_p);
    localparam logic [cw-1:0] n_c   = cw'(n_p);

    logic [cw-1:0] credits;
    logic [cw:0]   nxt;

    assign ok_o = (credits >= n_c);

    // Reserve is only issued while ok_o is high, so the subtraction cannot wrap.
    always_comb begin
        nxt = {1'b0, credits};
        if (release_i) nxt = nxt + (cw+1)'(1);
        if (reserve_i) nxt = nxt - n_w;
        if (nxt > max_w) nxt = max_w;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) credits <= cw'(max_p);
        else            credits <= nxt[cw-1:0];
    end
endmodule

// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// Read-return stage: buffers DRAM read words and steers each block to the cache of the oldest tag.
module bsg_cache_to_dram_ctrl_rx
    import bsg_cache_to_dram_ctrl_pkg::*;
#(
    parameter int num_cache_p           = 2,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 4,
    parameter int tag_fifo_els_p        = 4,
    parameter int data_fifo_els_p       = 8,
    localparam int lg_nc                = lg_num_cache(num_cache_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [lg_nc-1:0]        tag_i,
    output logic                    ready_o,
    input  logic                    app_rd_data_valid_i,
    input  logic [data_width_p-1:0] app_rd_data_i,
    input  logic                    app_rd_data_end_i,
    output logic [data_width_p-1:0] dma_data_o,
    output logic [num_cache_p-1:0]  dma_data_v_o,
    input  logic [num_cache_p-1:0]  dma_data_ready_i,
    output logic                    overflow_o,
    output logic                    protocol_err_o
);
    localparam int wc_w = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
    localparam logic [wc_w-1:0] last_word = wc_w'(block_size_in_words_p - 1);

    logic             ready_en;
    logic             tag_ready, tag_v, data_ready, data_v, credit_ok;
    logic [lg_nc-1:0] tag_head;
    logic [wc_w-1:0]  word_cnt;
    logic             tag_enq, xfer, tag_deq;

    assign ready_o = ready_en & tag_ready & credit_ok;
    assign tag_enq = v_i & ready_o;
    assign xfer    = |(dma_data_v_o & dma_data_ready_i);
    assign tag_deq = xfer & (word_cnt == last_word);

    always_comb begin
        dma_data_v_o = '0;
        for (int k = 0; k < num_cache_p; k++)
            dma_data_v_o[k] = data_v & tag_v & (tag_head == lg_nc'(k));
    end

    bsg_cache_to_dram_ctrl_fifo #(.width_p(lg_nc), .els_p(tag_fifo_els_p)) tag_fifo (
        .clk_i, .reset_n_i,
        .v_i(tag_enq), .data_i(tag_i), .ready_o(tag_ready),
        .v_o(tag_v), .data_o(tag_head), .yumi_i(tag_deq)
    );

    // DRAM words cannot be stalled; a word arriving into a full buffer is lost.
    bsg_cache_to_dram_ctrl_fifo #(.width_p(data_width_p), .els_p(data_fifo_els_p)) data_fifo (
        .clk_i, .reset_n_i,
        .v_i(app_rd_data_valid_i), .data_i(app_rd_data_i), .ready_o(data_ready),
        .v_o(data_v), .data_o(dma_data_o), .yumi_i(xfer)
    );

    bsg_cache_to_dram_ctrl_rx_credits #(.max_p(data_fifo_els_p), .n_p(block_size_in_words_p)) credits (
        .clk_i, .reset_n_i,
        .reserve_i(tag_enq), .release_i(xfer), .ok_o(credit_ok)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en       <= 1'b0;
            word_cnt       <= '0;
            overflow_o     <= 1'b0;
            protocol_err_o <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (xfer) word_cnt <= (word_cnt == last_word) ? '0 : word_cnt + 1'b1;
            if (app_rd_data_valid_i & ~data_ready)        overflow_o     <= 1'b1;
            if (app_rd_data_valid_i & ~app_rd_data_end_i) protocol_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_rx.sv
// Scoreboard bench for the read-return stage: directed stimulus, expected words queued, monitor on negedge.
module tb_bsg_cache_to_dram_ctrl_rx;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        v;
    logic [0:0]  tag;
    logic        ready;
    logic        app_valid;
    logic [31:0] app_data;
    logic        app_end;
    logic [31:0] dma_data;
    logic [1:0]  dma_v;
    logic [1:0]  dma_ready;
    logic        overflow;
    logic        protocol_err;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    int          xfer_cnt = 0;
    bit          hold_v = 0;
    logic [31:0] hold_d;

    bsg_cache_to_dram_ctrl_rx dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .v_i(v), .tag_i(tag), .ready_o(ready),
        .app_rd_data_valid_i(app_valid), .app_rd_data_i(app_data), .app_rd_data_end_i(app_end),
        .dma_data_o(dma_data), .dma_data_v_o(dma_v), .dma_data_ready_i(dma_ready),
        .overflow_o(overflow), .protocol_err_o(protocol_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic monitor_step();
        exp_t e;
        if (reset_n !== 1'b1) begin
            hold_v = 0;
        end else if (|dma_v) begin
            if (hold_v) chk("hold_stable", dma_data, hold_d);
            if (|(dma_v & dma_ready)) begin
                hold_v = 0;
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_word: got v=%b data=%0h expected none", dma_v, dma_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_valid", {30'd0, dma_v}, {30'd0, e.v});
                    chk("word_data", dma_data, e.d);
                end
            end else begin
                hold_v = 1;
                hold_d = dma_data;
            end
        end else begin
            hold_v = 0;
        end
    endtask

    task automatic send_tag(input logic t);
        int n = 0;
        while (!ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            checks++; fails++;
            $display("FAIL tag_timeout: got ready=0 expected ready=1");
        end else begin
            v = 1'b1; tag = t;
            @(posedge clk); #1;
            v = 1'b0;
        end
    endtask

    task automatic send_words(input logic [31:0] base, input int n, input logic [1:0] ev, input bit push);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (push) begin
                e.v = ev; e.d = base + i;
                exp_q.push_back(e);
            end
            app_valid = 1'b1; app_data = base + i; app_end = 1'b1;
            @(posedge clk); #1;
        end
        app_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic run_tests();
        int snap;
        // 1: reset with DRAM data present
        reset_n = 1'b0; v = 1'b0; tag = 1'b0;
        app_valid = 1'b1; app_data = 32'hDEAD; app_end = 1'b1; dma_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dma_v", {30'd0, dma_v}, 0);
        chk("reset_ready", {31'd0, ready}, 0);
        app_valid = 1'b0; dma_ready = 2'b00;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", {31'd0, ready}, 1);
        chk("post_reset_overflow", {31'd0, overflow}, 0);
        chk("post_reset_perr", {31'd0, protocol_err}, 0);

        // 2: single read to cache 1
        send_tag(1'b1);
        dma_ready = 2'b10;
        snap = xfer_cnt;
        send_words(32'hA0, 4, 2'b10, 1);
        wait_drain();
        chk("single_xfers", xfer_cnt - snap, 4);

        // 3: credit accounting
        send_tag(1'b0);
        send_tag(1'b1);
        chk("ready_no_credit", {31'd0, ready}, 0);
        dma_ready = 2'b01;
        send_words(32'hB0, 1, 2'b01, 1);
        @(posedge clk); #1;
        chk("ready_one_word", {31'd0, ready}, 0);
        send_words(32'hB1, 3, 2'b01, 1);
        @(posedge clk); #1;
        chk("ready_block_freed", {31'd0, ready}, 1);
        dma_ready = 2'b11;
        send_words(32'hC0, 4, 2'b10, 1);
        wait_drain();

        // 4: interleaved blocks, no bubbles
        dma_ready = 2'b11;
        send_tag(1'b0);
        send_tag(1'b1);
        snap = xfer_cnt;
        fork
            send_tag(1'b0);
            begin
                send_words(32'h100, 4, 2'b01, 1);
                send_words(32'h104, 4, 2'b10, 1);
                send_words(32'h108, 4, 2'b01, 1);
            end
        join
        @(posedge clk); #1;
        chk("interleave_no_bubble", xfer_cnt - snap, 12);
        wait_drain();

        // 5: cache 0 ready toggling
        dma_ready = 2'b00;
        send_tag(1'b0);
        snap = xfer_cnt;
        fork
            for (int i = 0; i < 10; i++) begin
                dma_ready[0] = ~dma_ready[0];
                @(posedge clk); #1;
            end
            send_words(32'hD0, 4, 2'b01, 1);
        join
        dma_ready = 2'b01;
        wait_drain();
        chk("backpressure_xfers", xfer_cnt - snap, 4);

        // 6: overflow with no tag outstanding, then protocol error
        dma_ready = 2'b11;
        chk("perr_clear", {31'd0, protocol_err}, 0);
        send_words(32'hE0, 8, 2'b00, 0);
        chk("overflow_not_yet", {31'd0, overflow}, 0);
        send_words(32'hE8, 1, 2'b00, 0);
        chk("overflow_set", {31'd0, overflow}, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("overflow_sticky", {31'd0, overflow}, 1);
        chk("untagged_not_presented", {30'd0, dma_v}, 0);
        app_valid = 1'b1; app_end = 1'b0; app_data = 32'hF0;
        @(posedge clk); #1;
        app_valid = 1'b0; app_end = 1'b1;
        chk("perr_set", {31'd0, protocol_err}, 1);
        @(posedge clk); #1;
        chk("perr_sticky", {31'd0, protocol_err}, 1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            run_tests();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
